// File: rtl/axi_default_slave_pkg.sv
// Shared definitions for the AXI default slave: bus widths, response codes
// and the state encodings of the write and read FSMs.
package axi_default_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    DS_W_IDLE = 2'd0,
    DS_W_DATA = 2'd1,
    DS_W_RESP = 2'd2
  } ds_w_state_e;

  typedef enum logic {
    DS_R_IDLE = 1'b0,
    DS_R_DATA = 1'b1
  } ds_r_state_e;

endpackage

// File: rtl/axi_default_slave_rd.sv
// Read side of the default slave: accepts one AR at a time and returns
// len+1 zero-data beats with DECERR. Outputs are registered from next-state.
module axi_default_slave_rd
  import axi_default_slave_pkg::*;
#(
  parameter int IDS_BITS  = AXI_IDS_BITS,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int LEN_BITS  = AXI_LEN_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IDS_BITS-1:0]  arid_i,
  input  logic [LEN_BITS-1:0]  arlen_i,
  input  logic                 arvalid_i,
  output logic                 arready_o,
  output logic [IDS_BITS-1:0]  rid_o,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic [1:0]           rresp_o,
  output logic                 rlast_o,
  output logic                 rvalid_o,
  input  logic                 rready_i
);

  ds_r_state_e         state_q, state_d;
  logic [IDS_BITS-1:0] id_q, id_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                ar_hs;
  logic                r_hs;

  assign ar_hs = arvalid_i & arready_q;
  assign r_hs  = rvalid_q & rready_i;

  // State, captured burst and registered outputs; reset abandons any burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DS_R_IDLE;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Next state; the counter stops on the last beat so it never wraps
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      DS_R_IDLE: begin
        if (ar_hs) begin
          state_d = DS_R_DATA;
          id_d    = arid_i;
          len_d   = arlen_i;
          cnt_d   = '0;
        end
      end
      DS_R_DATA: begin
        if (r_hs) begin
          if (rlast_q) state_d = DS_R_IDLE;
          else         cnt_d   = cnt_q + LEN_BITS'(1);
        end
      end
      default: state_d = DS_R_IDLE;
    endcase
  end

  // Output values decoded from the next state, registered above
  always_comb begin
    arready_d = (state_d == DS_R_IDLE);
    rvalid_d  = (state_d == DS_R_DATA);
    rlast_d   = (state_d == DS_R_DATA) && (cnt_d == len_d);
    rresp_d   = (state_d == DS_R_DATA) ? AXI_RESP_DECERR : rresp_q;
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rresp_o   = rresp_q;
  assign rid_o     = id_q;
  assign rdata_o   = '0;

endmodule

// File: rtl/axi_default_slave.sv
// AXI default slave: terminates every unmapped transaction with DECERR.
// Write FSM lives here; the read FSM is in axi_default_slave_rd.
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter int IDS_BITS  = AXI_IDS_BITS,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int LEN_BITS  = AXI_LEN_BITS
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [IDS_BITS-1:0]  AWID,
  input  logic [LEN_BITS-1:0]  AWLEN,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [IDS_BITS-1:0]  BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [IDS_BITS-1:0]  ARID,
  input  logic [LEN_BITS-1:0]  ARLEN,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [IDS_BITS-1:0]  RID,
  output logic [DATA_BITS-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);

  ds_w_state_e         w_state_q, w_state_d;
  logic [IDS_BITS-1:0] wid_q, wid_d;
  logic [LEN_BITS-1:0] wlen_q, wlen_d;
  logic [LEN_BITS-1:0] wcnt_q, wcnt_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign b_hs  = bvalid_q & BREADY;

  // Write state, captured burst and registered outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= DS_W_IDLE;
      wid_q     <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Next state; data phase ends on WLAST or on the AWLEN-th beat, whichever first
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    case (w_state_q)
      DS_W_IDLE: begin
        if (aw_hs) begin
          w_state_d = DS_W_DATA;
          wid_d     = AWID;
          wlen_d    = AWLEN;
          wcnt_d    = '0;
        end
      end
      DS_W_DATA: begin
        if (w_hs) begin
          if (WLAST || (wcnt_q == wlen_q)) w_state_d = DS_W_RESP;
          else                             wcnt_d    = wcnt_q + LEN_BITS'(1);
        end
      end
      DS_W_RESP: begin
        if (b_hs) w_state_d = DS_W_IDLE;
      end
      default: w_state_d = DS_W_IDLE;
    endcase
  end

  // Write output values decoded from the next state, registered above
  always_comb begin
    awready_d = (w_state_d == DS_W_IDLE);
    wready_d  = (w_state_d == DS_W_DATA);
    bvalid_d  = (w_state_d == DS_W_RESP);
    bresp_d   = (w_state_d == DS_W_RESP) ? AXI_RESP_DECERR : bresp_q;
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = wid_q;

  axi_default_slave_rd #(
    .IDS_BITS  (IDS_BITS),
    .DATA_BITS (DATA_BITS),
    .LEN_BITS  (LEN_BITS)
  ) u_rd (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .arid_i    (ARID),
    .arlen_i   (ARLEN),
    .arvalid_i (ARVALID),
    .arready_o (ARREADY),
    .rid_o     (RID),
    .rdata_o   (RDATA),
    .rresp_o   (RRESP),
    .rlast_o   (RLAST),
    .rvalid_o  (RVALID),
    .rready_i  (RREADY)
  );

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: scenario tasks with queue-based expectations
// for B responses and R beats.
module tb_axi_default_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  AWID;
  logic [3:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } r_exp_t;

  r_exp_t     rq[$];
  logic [7:0] bq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  axi_default_slave dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWID    (AWID),
    .AWLEN   (AWLEN),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WLAST   (WLAST),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BID     (BID),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARID    (ARID),
    .ARLEN   (ARLEN),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RID     (RID),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    AWID = '0; AWLEN = '0; AWVALID = 1'b0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs act=%h req=0",
               {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID});
    end
    ARESETn = 1'b1;
    tick();
    n_checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin
      n_fail++;
      $display("FAIL post_reset_ctrl act=%b req=11000", {AWREADY, ARREADY, WREADY, BVALID, RVALID});
    end
    n_checks++;
    if ({BID, RID, BRESP, RRESP} !== 20'h0) begin
      n_fail++;
      $display("FAIL post_reset_ids act=%h req=0", {BID, RID, BRESP, RRESP});
    end
  endtask

  // wlast_at: beat index carrying WLAST, or -1 for never
  task automatic run_write(input string name, input logic [7:0] id, input logic [3:0] len,
                           input int wlast_at);
    int         acc;
    logic [7:0] eid;
    acc = int'(len) + 1;
    if (wlast_at >= 0 && wlast_at + 1 < acc) acc = wlast_at + 1;
    AWID = id; AWLEN = len; AWVALID = 1'b1; BREADY = 1'b0;
    n_checks++;
    if (AWREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s awready act=%b req=1", name, AWREADY);
    end
    bq.push_back(id);
    tick();
    AWVALID = 1'b0; AWID = '0; AWLEN = '0;
    n_checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s after_aw act=%b req=010", name, {AWREADY, WREADY, BVALID});
    end
    for (int b = 0; b < acc; b++) begin
      WVALID = 1'b1;
      WLAST  = (b == wlast_at);
      n_checks++;
      if ({WREADY, BVALID} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s wbeat%0d act=%b req=10", name, b, {WREADY, BVALID});
      end
      tick();
    end
    WVALID = 1'b1; WLAST = 1'b0;
    eid = bq.pop_front();
    n_checks++;
    if ({WREADY, BVALID, BID, BRESP} !== {1'b0, 1'b1, eid, 2'b11}) begin
      n_fail++;
      $display("FAIL %s bresp act=%h req=%h", name, {WREADY, BVALID, BID, BRESP},
               {1'b0, 1'b1, eid, 2'b11});
    end
    tick();
    WVALID = 1'b0;
    n_checks++;
    if ({WREADY, BVALID, BID, BRESP} !== {1'b0, 1'b1, eid, 2'b11}) begin
      n_fail++;
      $display("FAIL %s b_hold act=%h req=%h", name, {WREADY, BVALID, BID, BRESP},
               {1'b0, 1'b1, eid, 2'b11});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    n_checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s after_b act=%b req=010", name, {BVALID, AWREADY, WREADY});
    end
  endtask

  // mode 0: RREADY toggles 1,0,1,...  mode 1: always 1  mode 2: random
  task automatic run_read(input string name, input logic [7:0] id, input logic [3:0] len,
                          input int mode);
    r_exp_t     e;
    int         beats;
    int         guard;
    logic       stalled;
    logic [7:0] prid;
    logic       plast;
    ARID = id; ARLEN = len; ARVALID = 1'b1;
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s arready act=%b req=1", name, ARREADY);
    end
    for (int b = 0; b <= int'(len); b++) begin
      e.id = id;
      e.last = (b == int'(len));
      rq.push_back(e);
    end
    tick();
    ARVALID = 1'b0; ARID = '0; ARLEN = '0;
    beats = 0; guard = 0; stalled = 1'b0; prid = '0; plast = 1'b0;
    while (rq.size() > 0 && guard < 200) begin
      case (mode)
        0:       RREADY = (guard % 2 == 0);
        1:       RREADY = 1'b1;
        default: RREADY = 1'($urandom_range(0, 1));
      endcase
      e = rq[0];
      n_checks++;
      if ({RVALID, ARREADY, RID, RDATA, RRESP, RLAST} !== {1'b1, 1'b0, e.id, 32'h0, 2'b11, e.last}) begin
        n_fail++;
        $display("FAIL %s rbeat%0d act=%h req=%h", name, beats,
                 {RVALID, ARREADY, RID, RDATA, RRESP, RLAST},
                 {1'b1, 1'b0, e.id, 32'h0, 2'b11, e.last});
      end
      if (stalled) begin
        n_checks++;
        if ({RID, RLAST} !== {prid, plast}) begin
          n_fail++;
          $display("FAIL %s stall_stable act=%h req=%h", name, {RID, RLAST}, {prid, plast});
        end
      end
      if (RREADY) begin
        void'(rq.pop_front());
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prid  = RID;
        plast = RLAST;
      end
      tick();
      guard++;
    end
    RREADY = 1'b0;
    n_checks++;
    if (beats != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s beat_count act=%0d req=%0d", name, beats, int'(len) + 1);
    end
    rq.delete();
    n_checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s after_r act=%b req=01", name, {RVALID, ARREADY});
    end
  endtask

  task automatic test_write_burst();
    run_write("wr_len3", 8'h5A, 4'd3, 3);
  endtask

  task automatic test_write_no_wlast();
    run_write("wr_nolast", 8'h33, 4'd1, -1);
  endtask

  task automatic test_write_early_wlast();
    run_write("wr_early", 8'h6C, 4'd3, 1);
  endtask

  task automatic test_read_stall();
    run_read("rd_stall", 8'h21, 4'd2, 0);
  endtask

  task automatic test_read_bounds();
    run_read("rd_len0", 8'h0F, 4'd0, 1);
    run_read("rd_len15", 8'hE3, 4'd15, 2);
  endtask

  task automatic test_simultaneous();
    r_exp_t     e;
    logic [7:0] eid;
    AWID = 8'h77; AWLEN = 4'd0; AWVALID = 1'b1;
    ARID = 8'h44; ARLEN = 4'd1; ARVALID = 1'b1;
    BREADY = 1'b0;
    bq.push_back(8'h77);
    e.id = 8'h44; e.last = 1'b0; rq.push_back(e);
    e.id = 8'h44; e.last = 1'b1; rq.push_back(e);
    n_checks++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      n_fail++;
      $display("FAIL sim_ready act=%b req=11", {AWREADY, ARREADY});
    end
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    eid = bq.pop_front();
    for (int i = 0; i < 6; i++) begin
      WVALID = (i == 0); WLAST = 1'b1; RREADY = 1'b1;
      if (i > 0) begin
        n_checks++;
        if ({BVALID, BID, BRESP} !== {1'b1, eid, 2'b11}) begin
          n_fail++;
          $display("FAIL sim_b_hold%0d act=%h req=%h", i, {BVALID, BID, BRESP}, {1'b1, eid, 2'b11});
        end
      end
      if (RVALID) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sim_extra_rbeat act=%h req=none", {RID, RLAST});
        end else begin
          e = rq.pop_front();
          n_checks++;
          if ({RID, RRESP, RLAST} !== {e.id, 2'b11, e.last}) begin
            n_fail++;
            $display("FAIL sim_rbeat act=%h req=%h", {RID, RRESP, RLAST}, {e.id, 2'b11, e.last});
          end
        end
      end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
    n_checks++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL sim_r_left act=%0d req=0", rq.size());
    end
    rq.delete();
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    n_checks++;
    if ({BVALID, AWREADY, RVALID, ARREADY} !== 4'b0101) begin
      n_fail++;
      $display("FAIL sim_done act=%b req=0101", {BVALID, AWREADY, RVALID, ARREADY});
    end
  endtask

  task automatic test_reset_mid_read();
    ARID = 8'h99; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    n_checks++;
    if ({RVALID, RID, RLAST} !== {1'b1, 8'h99, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_beat2 act=%h req=%h", {RVALID, RID, RLAST}, {1'b1, 8'h99, 1'b0});
    end
    #2 ARESETn = 1'b0;
    #1;
    n_checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset act=%h req=0",
               {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID});
    end
    RREADY = 1'b0;
    repeat (2) tick();
    ARESETn = 1'b1;
    tick();
    n_checks++;
    if ({ARREADY, AWREADY, RVALID, RID, RRESP} !== {1'b1, 1'b1, 1'b0, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_release act=%h req=%h", {ARREADY, AWREADY, RVALID, RID, RRESP},
               {1'b1, 1'b1, 1'b0, 8'h00, 2'b00});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({RVALID, ARREADY} !== 2'b01) begin
        n_fail++;
        $display("FAIL mid_no_stale%0d act=%b req=01", i, {RVALID, ARREADY});
      end
    end
    run_read("rd_after_rst", 8'h5C, 4'd1, 1);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_stall();
    test_write_no_wlast();
    test_write_early_wlast();
    test_read_bounds();
    test_simultaneous();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
